// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Op codes follow the RISC-V M-extension funct3 field; state encoding for the
// iterative FSM; helper producing the most-negative two's-complement value.
package ex_pkg;

  // funct3 op encoding
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Most-negative value for an xlen-bit operand, right-aligned in 64 bits.
  function automatic logic [63:0] md_most_neg(input int xlen);
    md_most_neg = 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Unsigned radix-2 shift engine: shift-add multiply or restoring divide.
// Latency: one step per cycle while step=1; XLEN steps give the full result.
// Backpressure: none; the controlling FSM decides when to load and step.
// Ports: load/ld_x/ld_y seed the engine (x = multiplier or dividend,
//   y = multiplicand or divisor); step advances one iteration in the mode
//   chosen by mode_div; prod_hi/prod_lo and quo/rem expose the result views.
module ex_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            mode_div,
  input  logic [XLEN-1:0] ld_x,
  input  logic [XLEN-1:0] ld_y,
  output logic [XLEN-1:0] prod_hi,
  output logic [XLEN-1:0] prod_lo,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  // hi: product high half / partial remainder (one guard bit)
  // lo: product low half with multiplier bits / dividend bits turning into quotient
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] y_q, y_d;

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    y_d  = y_q;

    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole pair right.
    sum  = hi_q + (lo_q[0] ? {1'b0, y_q} : '0);
    // Divide: bring the next dividend bit into the partial remainder.
    shl  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    // Remainder stays below the divisor, so bit XLEN of the difference is a
    // reliable borrow/sign indicator.
    diff = shl - {1'b0, y_q};

    if (load) begin
      hi_d = '0;
      lo_d = ld_x;
      y_d  = ld_y;
    end else if (step) begin
      if (mode_div) begin
        if (!diff[XLEN]) begin
          hi_d = diff;
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shl;
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = {1'b0, sum[XLEN:1]};
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      y_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      y_q  <= y_d;
    end
  end

  assign prod_hi = hi_q[XLEN-1:0];
  assign prod_lo = lo_q;
  assign quo     = lo_q;
  assign rem     = hi_q[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit for the EX stage.
// Latency: start in cycle 0 -> done in cycle XLEN+1 (cycle 1 for div-by-zero/overflow).
// Backpressure: start accepted only in IDLE with kill=0; busy high while iterating.
// Ports: start/op/a/b request an op; kill flushes an in-flight op without done;
//   busy marks iteration; done pulses one cycle with result valid; result holds
//   the last completed value until the next completion.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(md_most_neg(XLEN));

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            spc_q, spc_d;
  logic [XLEN-1:0] spc_val_q, spc_val_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand conditioning (on the live inputs, used only on accept)
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in;
  logic            div0, ovf, special;
  logic [XLEN-1:0] spc_val;
  logic            accept;

  // Engine interface
  logic            eng_load, eng_step;
  logic [XLEN-1:0] eng_hi, eng_lo, eng_quo, eng_rem;

  // Result formation
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, calc_val, done_val;

  always_comb begin
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
    a_mag   = a;
    b_mag   = b;
    neg_in  = 1'b0;
    div0    = 1'b0;
    ovf     = 1'b0;
    special = 1'b0;
    spc_val = '0;

    a_sgn  = ((op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM))
             && a[XLEN-1];
    b_sgn  = ((op == MD_MULH) || (op == MD_DIV) || (op == MD_REM)) && b[XLEN-1];
    a_mag  = a_sgn ? -a : a;
    b_mag  = b_sgn ? -b : b;
    // Remainder takes the dividend's sign; products and quotients the xor.
    // MUL needs no sign fix: the low half is identical signed or unsigned.
    neg_in = (op == MD_REM) ? a_sgn : (a_sgn ^ b_sgn);

    div0    = op[2] && (b == '0);
    ovf     = ((op == MD_DIV) || (op == MD_REM)) && (a == MOST_NEG) && (b == '1);
    special = div0 || ovf;
    // op[1] separates REM/REMU from DIV/DIVU
    if (div0) begin
      spc_val = op[1] ? a : '1;
    end else if (ovf) begin
      spc_val = op[1] ? '0 : a;
    end
  end

  assign accept = (state_q == MD_IDLE) && start && !kill;

  ex_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (eng_load),
    .step    (eng_step),
    .mode_div(op_q[2]),
    .ld_x    (a_mag),
    .ld_y    (b_mag),
    .prod_hi (eng_hi),
    .prod_lo (eng_lo),
    .quo     (eng_quo),
    .rem     (eng_rem)
  );

  // Sign fix-up on the finished magnitudes; valid while in DONE.
  always_comb begin
    prod     = {eng_hi, eng_lo};
    prod_s   = neg_q ? -prod : prod;
    quo_s    = neg_q ? -eng_quo : eng_quo;
    rem_s    = neg_q ? -eng_rem : eng_rem;
    calc_val = rem_s;
    case (op_q)
      MD_MUL:                       calc_val = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_val = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              calc_val = quo_s;
      default:                      calc_val = rem_s;
    endcase
    done_val = spc_q ? spc_val_q : calc_val;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    spc_d     = spc_q;
    spc_val_d = spc_val_q;
    result_d  = result_q;
    eng_load  = 1'b0;
    eng_step  = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d      = op;
          neg_d     = neg_in;
          spc_d     = special;
          spc_val_d = spc_val;
          if (special) begin
            state_d = MD_DONE;
          end else begin
            eng_load = 1'b1;
            cnt_d    = CW'(XLEN - 1);
            state_d  = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (kill) begin
          state_d = MD_IDLE;
        end else begin
          eng_step = 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        // A kill here discards the op, so the held result is left alone.
        if (!kill) begin
          result_d = done_val;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      spc_q     <= 1'b0;
      spc_val_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      spc_q     <= spc_d;
      spc_val_q <= spc_val_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == MD_CALC);
  assign done   = (state_q == MD_DONE) && !kill;
  assign result = done ? done_val : result_q;

endmodule
